// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line engine: the descriptor layout,
// the fill FSM states and the field widths used across the block.
package sprite_pkg;

    localparam int DESC_W  = 32;
    localparam int COORD_W = 10;
    localparam int ID_W    = 5;
    localparam int POS_W   = COORD_W + 1;

    localparam logic [23:0] TRANSPARENT = 24'h000000;

    typedef struct packed {
        logic               en;
        logic [5:0]         rsvd;
        logic [ID_W-1:0]    id;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } sprite_desc_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        FETCH,
        DRAIN
    } fsm_t;

    // Vertical coverage test done one bit wider than the coordinates so y+size never wraps.
    function automatic logic sprite_on_line(input sprite_desc_t d,
                                            input logic [COORD_W-1:0] line,
                                            input int size);
        logic [POS_W-1:0] top;
        logic [POS_W-1:0] bot;
        logic [POS_W-1:0] ln;
        top = {1'b0, d.y};
        bot = top + POS_W'(size - 1);
        ln  = {1'b0, line};
        return d.en && (ln >= top) && (ln <= bot);
    endfunction

endpackage

// File: rtl/sprite_line_buffer.sv
// One line of pixels: a single write port and a registered read port.
module sprite_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 24,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sprite_line_engine.sv
// Double-buffered sprite line renderer: while line v is displayed, the back
// buffer is cleared and filled with the sprites covering line v+1.
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int SPRITE_SIZE = 32,
    parameter int ROM_LAT     = 2,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int COLOR_W     = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SPRITES*32-1:0]  sprite_desc,
    input  logic [9:0]                 VGA_HCOUNT,
    input  logic [9:0]                 VGA_VCOUNT,
    output logic                       rom_rd,
    output logic [4:0]                 rom_id,
    output logic [9:0]                 rom_addr,
    input  logic [COLOR_W-1:0]         rom_data,
    output logic [7:0]                 VGA_R,
    output logic [7:0]                 VGA_G,
    output logic [7:0]                 VGA_B,
    output logic                       busy,
    output logic                       overrun
);

    localparam int COL_W = $clog2(SPRITE_SIZE);
    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]   H_LIM  = POS_W'(H_ACTIVE);

    fsm_t                 state_q, state_d;
    logic [COORD_W-1:0]   vcount_q, vcount_d;
    logic [COORD_W-1:0]   target_q, target_d;
    logic                 disp_sel_q, disp_sel_d;
    logic                 disp_valid_q, disp_valid_d;
    logic                 overrun_q, overrun_d;
    logic [COORD_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [LAT_W-1:0]     drain_q, drain_d;
    logic                 pix_ok_q, pix_ok_d;
    logic                 rd_sel_q, rd_sel_d;
    sprite_desc_t         shadow_q [NUM_SPRITES];
    sprite_desc_t         shadow_d [NUM_SPRITES];
    logic                 pipe_vld_q [ROM_LAT];
    logic                 pipe_vld_d [ROM_LAT];
    logic [POS_W-1:0]     pipe_x_q [ROM_LAT];
    logic [POS_W-1:0]     pipe_x_d [ROM_LAT];

    logic                 line_start;
    sprite_desc_t         cur;
    logic                 hit;
    logic [COORD_W-1:0]   row;
    logic                 fetch_rd;
    logic                 fill_we;
    logic                 out_vld;
    logic [POS_W-1:0]     out_x;
    logic                 sprite_we;
    logic                 wr_en;
    logic [COORD_W-1:0]   wr_addr;
    logic [COLOR_W-1:0]   wr_data;
    logic [COORD_W-1:0]   rd_addr;
    logic [COLOR_W-1:0]   rdata0, rdata1;
    logic [COLOR_W-1:0]   pix;
    logic                 unused_bits;

    assign line_start = (VGA_VCOUNT != vcount_q);
    assign cur        = shadow_q[idx_q];
    assign hit        = sprite_on_line(cur, target_q, SPRITE_SIZE);
    assign row        = target_q - cur.y;
    assign unused_bits = ^{cur.rsvd, row[COORD_W-1:COL_W]};

    // Fill sequencer; a line change always wins and restarts from CLEAR.
    always_comb begin
        state_d      = state_q;
        vcount_d     = VGA_VCOUNT;
        target_d     = target_q;
        disp_sel_d   = disp_sel_q;
        disp_valid_d = disp_valid_q;
        overrun_d    = overrun_q;
        clr_cnt_d    = clr_cnt_q;
        idx_d        = idx_q;
        col_d        = col_q;
        drain_d      = drain_q;
        shadow_d     = shadow_q;
        fill_we      = 1'b0;
        fetch_rd     = 1'b0;

        case (state_q)
            IDLE: ;
            CLEAR: begin
                fill_we = 1'b1;
                if (clr_cnt_q == H_LAST) begin
                    clr_cnt_d = '0;
                    if (target_q >= V_ACT) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SCAN;
                        idx_d   = IDX_W'(NUM_SPRITES - 1);
                    end
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            SCAN: begin
                if (hit) begin
                    state_d = FETCH;
                    col_d   = '0;
                end else if (idx_q == '0) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            FETCH: begin
                fetch_rd = 1'b1;
                if (col_q == COL_W'(SPRITE_SIZE - 1)) begin
                    if (idx_q == '0) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q - 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == LAT_W'(ROM_LAT - 1)) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (line_start) begin
            overrun_d    = overrun_q | (state_q != IDLE);
            target_d     = (VGA_VCOUNT == V_LAST) ? '0 : VGA_VCOUNT + 1'b1;
            disp_sel_d   = ~disp_sel_q;
            disp_valid_d = 1'b1;
            state_d      = CLEAR;
            clr_cnt_d    = '0;
            fill_we      = 1'b0;
            fetch_rd     = 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_d[i] = sprite_desc_t'(sprite_desc[32*i +: 32]);
            end
        end
    end

    // ROM request side; the x position travels alongside the read until the data returns.
    always_comb begin
        pipe_vld_d[0] = fetch_rd;
        pipe_x_d[0]   = {1'b0, cur.x} + POS_W'(col_q);
        for (int k = 1; k < ROM_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1] && !line_start;
            pipe_x_d[k]   = pipe_x_q[k-1];
        end
    end

    assign rom_rd   = fetch_rd;
    assign rom_id   = cur.id;
    assign rom_addr = COORD_W'({row[COL_W-1:0], col_q});

    assign out_vld   = pipe_vld_q[ROM_LAT-1] && !line_start;
    assign out_x     = pipe_x_q[ROM_LAT-1];
    assign sprite_we = out_vld && (rom_data != COLOR_W'(TRANSPARENT)) && (out_x < H_LIM);

    assign wr_en   = fill_we | sprite_we;
    assign wr_addr = fill_we ? clr_cnt_q : out_x[COORD_W-1:0];
    assign wr_data = fill_we ? '0 : rom_data;

    // Display side uses the post-swap select so a line change takes effect immediately.
    assign rd_addr  = (VGA_HCOUNT < H_ACT) ? VGA_HCOUNT : '0;
    assign pix_ok_d = disp_valid_d && (VGA_HCOUNT < H_ACT) && (VGA_VCOUNT < V_ACT);
    assign rd_sel_d = disp_sel_d;

    sprite_line_buffer #(
        .DEPTH  (H_ACTIVE),
        .DATA_W (COLOR_W),
        .ADDR_W (COORD_W)
    ) u_buf0 (
        .clk   (clk),
        .we    (wr_en && disp_sel_q),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    sprite_line_buffer #(
        .DEPTH  (H_ACTIVE),
        .DATA_W (COLOR_W),
        .ADDR_W (COORD_W)
    ) u_buf1 (
        .clk   (clk),
        .we    (wr_en && !disp_sel_q),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            vcount_q     <= 10'h3FF;
            disp_sel_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            clr_cnt_q    <= '0;
            idx_q        <= '0;
            col_q        <= '0;
            drain_q      <= '0;
            pix_ok_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            vcount_q     <= vcount_d;
            disp_sel_q   <= disp_sel_d;
            disp_valid_q <= disp_valid_d;
            overrun_q    <= overrun_d;
            clr_cnt_q    <= clr_cnt_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            drain_q      <= drain_d;
            pix_ok_q     <= pix_ok_d;
            rd_sel_q     <= rd_sel_d;
            pipe_vld_q   <= pipe_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        target_q <= target_d;
        shadow_q <= shadow_d;
        pipe_x_q <= pipe_x_d;
    end

    assign pix = pix_ok_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
    assign {VGA_R, VGA_G, VGA_B} = pix;

    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine with a two-cycle-latency ROM model.
module tb_sprite_line_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] sprite_desc;
    logic [9:0]   VGA_HCOUNT;
    logic [9:0]   VGA_VCOUNT;
    logic         rom_rd;
    logic [4:0]   rom_id;
    logic [9:0]   rom_addr;
    logic [23:0]  rom_data = 24'hABCDEF;
    logic [7:0]   VGA_R, VGA_G, VGA_B;
    logic         busy;
    logic         overrun;

    int checks   = 0;
    int failures = 0;
    int rom_total = 0;
    int rom_base  = 0;
    logic [9:0] addr_log [4096];

    logic        rd_d1 = 1'b0;
    logic [4:0]  id_d1;
    logic [9:0]  addr_d1;

    always #5 clk = ~clk;

    sprite_line_engine dut (
        .clk         (clk),
        .reset       (reset),
        .sprite_desc (sprite_desc),
        .VGA_HCOUNT  (VGA_HCOUNT),
        .VGA_VCOUNT  (VGA_VCOUNT),
        .rom_rd      (rom_rd),
        .rom_id      (rom_id),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .busy        (busy),
        .overrun     (overrun)
    );

    function automatic logic [23:0] rom_word(input logic [4:0] id, input logic [9:0] a);
        case (id)
            5'd2:    return 24'hFF0000;
            5'd4:    return 24'h00FF00;
            5'd5:    return 24'h0000FF;
            5'd6:    return (a == 10'd0) ? 24'h000000 : 24'h00FF00;
            default: return 24'h000000;
        endcase
    endfunction

    // ROM answers two clocks after the strobe; garbage otherwise.
    always @(posedge clk) begin
        rd_d1    <= rom_rd;
        id_d1    <= rom_id;
        addr_d1  <= rom_addr;
        rom_data <= rd_d1 ? rom_word(id_d1, addr_d1) : 24'hABCDEF;
        if (rom_rd === 1'b1) begin
            addr_log[rom_total % 4096] <= rom_addr;
            rom_total <= rom_total + 1;
        end
    end

    function automatic logic [31:0] mk_desc(input logic en, input logic [4:0] id,
                                            input logic [9:0] y, input logic [9:0] x);
        return {en, 6'b0, id, y, x};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_idle_timeout busy=%b expected 0", tag, busy);
            failures++;
        end
    endtask

    task automatic new_line(input logic [9:0] v, input string tag);
        VGA_HCOUNT = 10'd700;
        VGA_VCOUNT = v;
        rom_base   = rom_total;
        step();
        wait_idle(tag);
    endtask

    task automatic pix_at(input logic [9:0] h, output logic [23:0] p);
        VGA_HCOUNT = h;
        step();
        p = {VGA_R, VGA_G, VGA_B};
    endtask

    task automatic test_reset();
        logic [23:0] p;
        reset = 1'b1;
        sprite_desc = '0;
        VGA_VCOUNT = 10'd0;
        VGA_HCOUNT = 10'd5;
        repeat (3) step();
        p = {VGA_R, VGA_G, VGA_B};
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); failures++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun got=%b exp=0", overrun); failures++; end
        checks++; if (rom_rd !== 1'b0) begin $display("FAIL reset_rom_rd got=%b exp=0", rom_rd); failures++; end
        checks++; if (p !== 24'h0) begin $display("FAIL reset_pixel got=%h exp=000000", p); failures++; end
        rom_base = rom_total;
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b1) begin $display("FAIL reset_first_line_start busy=%b exp=1", busy); failures++; end
        wait_idle("reset");
        checks++;
        if (rom_total - rom_base != 0) begin
            $display("FAIL reset_no_rom_reads got=%0d exp=0", rom_total - rom_base); failures++;
        end
    endtask

    task automatic test_basic();
        int hs [6];
        logic [23:0] ex [6];
        logic [23:0] p;
        sprite_desc = '0;
        sprite_desc[31:0] = mk_desc(1'b1, 5'd2, 10'd10, 10'd100);
        new_line(10'd9, "basic9");
        checks++;
        if (rom_total - rom_base != 32) begin
            $display("FAIL basic_rom_count got=%0d exp=32", rom_total - rom_base); failures++;
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (addr_log[(rom_base + i) % 4096] !== 10'(i)) begin
                $display("FAIL basic_rom_addr%0d got=%0d exp=%0d", i, addr_log[(rom_base + i) % 4096], i);
                failures++;
            end
        end
        new_line(10'd10, "basic10");
        hs = '{99, 100, 115, 131, 132, 0};
        ex = '{24'h0, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'h0, 24'h0};
        for (int i = 0; i < 6; i++) begin
            pix_at(10'(hs[i]), p);
            checks++;
            if (p !== ex[i]) begin
                $display("FAIL basic_px%0d got=%h exp=%h", hs[i], p, ex[i]); failures++;
            end
        end
    endtask

    task automatic test_priority();
        int hs [4];
        logic [23:0] ex [4];
        logic [23:0] p;
        sprite_desc = '0;
        sprite_desc[31:0]  = mk_desc(1'b1, 5'd4, 10'd10, 10'd100);
        sprite_desc[63:32] = mk_desc(1'b1, 5'd5, 10'd10, 10'd100);
        new_line(10'd9, "prio9");
        checks++;
        if (rom_total - rom_base != 64) begin
            $display("FAIL prio_rom_count got=%0d exp=64", rom_total - rom_base); failures++;
        end
        new_line(10'd10, "prio10");
        hs = '{99, 100, 131, 132};
        ex = '{24'h0, 24'h00FF00, 24'h00FF00, 24'h0};
        for (int i = 0; i < 4; i++) begin
            pix_at(10'(hs[i]), p);
            checks++;
            if (p !== ex[i]) begin
                $display("FAIL prio_px%0d got=%h exp=%h", hs[i], p, ex[i]); failures++;
            end
        end
    endtask

    task automatic test_transparency();
        int hs [3];
        logic [23:0] ex [3];
        logic [23:0] p;
        sprite_desc = '0;
        sprite_desc[31:0]  = mk_desc(1'b1, 5'd6, 10'd10, 10'd100);
        sprite_desc[63:32] = mk_desc(1'b1, 5'd5, 10'd10, 10'd100);
        new_line(10'd9, "transp9");
        new_line(10'd10, "transp10");
        hs = '{100, 101, 131};
        ex = '{24'h0000FF, 24'h00FF00, 24'h00FF00};
        for (int i = 0; i < 3; i++) begin
            pix_at(10'(hs[i]), p);
            checks++;
            if (p !== ex[i]) begin
                $display("FAIL transp_px%0d got=%h exp=%h", hs[i], p, ex[i]); failures++;
            end
        end
    endtask

    task automatic test_clip();
        int hs [5];
        logic [23:0] ex [5];
        logic [23:0] p;
        sprite_desc = '0;
        sprite_desc[31:0] = mk_desc(1'b1, 5'd2, 10'd10, 10'd620);
        new_line(10'd9, "clip9");
        checks++;
        if (rom_total - rom_base != 32) begin
            $display("FAIL clip_rom_count got=%0d exp=32", rom_total - rom_base); failures++;
        end
        new_line(10'd10, "clip10");
        hs = '{619, 620, 639, 0, 11};
        ex = '{24'h0, 24'hFF0000, 24'hFF0000, 24'h0, 24'h0};
        for (int i = 0; i < 5; i++) begin
            pix_at(10'(hs[i]), p);
            checks++;
            if (p !== ex[i]) begin
                $display("FAIL clip_px%0d got=%h exp=%h", hs[i], p, ex[i]); failures++;
            end
        end
        new_line(10'd11, "clip11");
        pix_at(10'd0, p);
        checks++; if (p !== 24'h0) begin $display("FAIL clip_next_px0 got=%h exp=000000", p); failures++; end
        pix_at(10'd630, p);
        checks++; if (p !== 24'hFF0000) begin $display("FAIL clip_next_px630 got=%h exp=FF0000", p); failures++; end
    endtask

    task automatic test_wrap();
        logic [23:0] p;
        sprite_desc = '0;
        sprite_desc[31:0] = mk_desc(1'b1, 5'd2, 10'd0, 10'd0);
        new_line(10'd524, "wrap524");
        checks++;
        if (rom_total - rom_base != 32) begin
            $display("FAIL wrap_rom_count got=%0d exp=32", rom_total - rom_base); failures++;
        end
        checks++;
        if (addr_log[(rom_base + 31) % 4096] !== 10'd31) begin
            $display("FAIL wrap_last_addr got=%0d exp=31", addr_log[(rom_base + 31) % 4096]); failures++;
        end
        new_line(10'd0, "wrap0");
        pix_at(10'd0, p);
        checks++; if (p !== 24'hFF0000) begin $display("FAIL wrap_px0 got=%h exp=FF0000", p); failures++; end
        pix_at(10'd32, p);
        checks++; if (p !== 24'h0) begin $display("FAIL wrap_px32 got=%h exp=000000", p); failures++; end
        sprite_desc[31:0] = mk_desc(1'b0, 5'd2, 10'd0, 10'd0);
        new_line(10'd524, "wrap_dis");
        checks++;
        if (rom_total - rom_base != 0) begin
            $display("FAIL wrap_disabled_rom_count got=%0d exp=0", rom_total - rom_base); failures++;
        end
        pix_at(10'd0, p);
        checks++; if (p !== 24'h0) begin $display("FAIL vblank_px0 got=%h exp=000000", p); failures++; end
        sprite_desc[31:0] = mk_desc(1'b1, 5'd2, 10'd490, 10'd0);
        new_line(10'd500, "vblank500");
        checks++;
        if (rom_total - rom_base != 0) begin
            $display("FAIL vblank_rom_count got=%0d exp=0", rom_total - rom_base); failures++;
        end
    endtask

    task automatic test_overrun();
        sprite_desc = '0;
        sprite_desc[31:0] = mk_desc(1'b1, 5'd2, 10'd100, 10'd0);
        VGA_VCOUNT = 10'd99;
        step();
        checks++; if (busy !== 1'b1) begin $display("FAIL ovr_busy_start got=%b exp=1", busy); failures++; end
        repeat (199) step();
        checks++; if (overrun !== 1'b0) begin $display("FAIL ovr_before got=%b exp=0", overrun); failures++; end
        VGA_VCOUNT = 10'd100;
        rom_base = rom_total;
        step();
        checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_set got=%b exp=1", overrun); failures++; end
        checks++; if (busy !== 1'b1) begin $display("FAIL ovr_busy_restart got=%b exp=1", busy); failures++; end
        wait_idle("ovr");
        checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_sticky got=%b exp=1", overrun); failures++; end
        checks++;
        if (rom_total - rom_base != 32) begin
            $display("FAIL ovr_rom_count got=%0d exp=32", rom_total - rom_base); failures++;
        end
        checks++;
        if (addr_log[rom_base % 4096] !== 10'd32) begin
            $display("FAIL ovr_first_addr got=%0d exp=32", addr_log[rom_base % 4096]); failures++;
        end
        reset = 1'b1;
        step();
        checks++; if (overrun !== 1'b0) begin $display("FAIL ovr_cleared got=%b exp=0", overrun); failures++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL ovr_reset_busy got=%b exp=0", busy); failures++; end
        reset = 1'b0;
        step();
        wait_idle("ovr_post");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog_timeout time=%0t exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_transparency();
        test_clip();
        test_wrap();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
